// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pkg                                                              |
// | Shared types and default dimensions for the VGA frame reader.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package vga_pkg;

   typedef enum logic [1:0] {
      NATIVE    = 2'd0,
      UPSCALE2X = 2'd1,
      CENTER    = 2'd2,
      RSVD      = 2'd3
   } vga_mode_e;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   localparam int DEF_IMG_W  = 320;
   localparam int DEF_IMG_H  = 240;
   localparam int DEF_SCR_W  = 640;
   localparam int DEF_SCR_H  = 480;
   localparam int DEF_ADDR_W = 17;

endpackage
`default_nettype wire

// File: rtl/vga_frame_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_frame_reader_if                                                  |
// | Frame-buffer BRAM read port: enable, address, RGB444 read data.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface vga_frame_reader_if #(
   parameter int ADDR_W = 17
);
   logic              rEn;
   logic [ADDR_W-1:0] rAddr;
   logic [11:0]       rData;

   // Reader side: issues reads, consumes data
   modport master (output rEn, output rAddr, input rData);
   // Memory side: serves reads
   modport slave  (input rEn, input rAddr, output rData);
endinterface
`default_nettype wire

// File: rtl/vga_pipe_delay.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_pipe_delay                                                       |
// | Fixed-depth register delay line, cleared to zero on reset.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_pipe_delay #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   genvar g;
   generate
      for (g = 0; g < DEPTH; g++) begin : g_stage
         logic [WIDTH-1:0] q;
         if (g == 0) begin : g_first
            // First stage captures the input
            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) q <= '0;
               else          q <= din;
            end
         end else begin : g_next
            // Later stages shift the previous stage along
            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) q <= '0;
               else          q <= g_stage[g-1].q;
            end
         end
      end
   endgenerate

   assign dout = g_stage[DEPTH-1].q;

endmodule
`default_nettype wire

// File: rtl/vga_frame_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_frame_reader                                                     |
// | Raster-to-BRAM address generator (native / 2x / centred placement)   |
// | with BRAM latency compensation so colour and de stay aligned.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_frame_reader
   import vga_pkg::*;
#(
   parameter int IMG_W  = DEF_IMG_W,
   parameter int IMG_H  = DEF_IMG_H,
   parameter int SCR_W  = DEF_SCR_W,
   parameter int SCR_H  = DEF_SCR_H,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int RD_LAT = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [9:0]           x_coor,
   input  logic [8:0]           y_coor,
   input  logic                 display_en,
   input  logic [1:0]           mode,
   input  logic [11:0]          border_rgb,
   vga_frame_reader_if.master   bram,
   output logic                 de,
   output logic [3:0]           vgaRed,
   output logic [3:0]           vgaGreen,
   output logic [3:0]           vgaBlue
);

   localparam logic [10:0]       X_OFF    = 11'((SCR_W - IMG_W) / 2);
   localparam logic [10:0]       Y_OFF    = 11'((SCR_H - IMG_H) / 2);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

   vga_mode_e         mode_q, mode_in, mode_cur;
   logic              frame_ok, frame_start, ok_cur, upscale;
   logic [10:0]       x_rel, y_rel, win_w, win_h;
   logic              in_win, issue;
   logic [ADDR_W-1:0] col_cnt, row_base, col_eff, base_eff, addr, col_nxt, row_nxt;
   logic              issue_d, de_d;
   rgb444_t           pix_q;

   // Window compare and counter-based address for the current raster pixel
   always_comb begin
      frame_start = (x_coor == 10'd0) && (y_coor == 9'd0);
      mode_in     = vga_mode_e'(mode);
      if (mode_in == RSVD) mode_in = NATIVE;
      // The frame-start pixel already uses the mode being latched
      mode_cur    = frame_start ? mode_in : mode_q;
      ok_cur      = frame_ok | frame_start;
      upscale     = (mode_cur == UPSCALE2X);
      x_rel       = {1'b0, x_coor};
      y_rel       = {2'b00, y_coor};
      win_w       = 11'(IMG_W);
      win_h       = 11'(IMG_H);
      if (upscale) begin
         win_w = 11'(2 * IMG_W);
         win_h = 11'(2 * IMG_H);
      end
      // Left/above the centred window wraps to a huge value and fails the compare
      if (mode_cur == CENTER) begin
         x_rel = x_rel - X_OFF;
         y_rel = y_rel - Y_OFF;
      end
      in_win   = display_en && (x_rel < win_w) && (y_rel < win_h);
      issue    = in_win && ok_cur;
      col_eff  = (x_rel == 11'd0) ? '0 : col_cnt;
      base_eff = frame_start ? '0 : row_base;
      addr     = base_eff + col_eff;
      col_nxt  = col_cnt;
      row_nxt  = base_eff;
      if (in_win) begin
         col_nxt = (!upscale || x_rel[0]) ? col_eff + 1'b1 : col_eff;
         if ((x_rel == win_w - 11'd1) && (!upscale || y_rel[0])) begin
            row_nxt = base_eff + ROW_STEP;
         end
      end
   end

   // Frame state, address counters and the registered BRAM request
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_q     <= NATIVE;
         frame_ok   <= 1'b0;
         col_cnt    <= '0;
         row_base   <= '0;
         bram.rEn   <= 1'b0;
         bram.rAddr <= '0;
      end else begin
         if (frame_start) begin
            mode_q   <= mode_in;
            frame_ok <= 1'b1;
         end
         col_cnt    <= col_nxt;
         row_base   <= row_nxt;
         bram.rEn   <= issue;
         bram.rAddr <= issue ? addr : '0;
      end
   end

   // Read-issued and visible flags ride alongside the BRAM latency
   vga_pipe_delay #(
      .DEPTH (RD_LAT + 1),
      .WIDTH (2)
   ) u_flag_pipe (
      .clk     (clk),
      .reset_n (reset_n),
      .din     ({issue, display_en}),
      .dout    ({issue_d, de_d})
   );

   // Output register: image data, border colour or black during blanking
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         de    <= 1'b0;
         pix_q <= '0;
      end else begin
         de <= de_d;
         if (!de_d)        pix_q <= '0;
         else if (issue_d) pix_q <= rgb444_t'(bram.rData);
         else              pix_q <= rgb444_t'(border_rgb);
      end
   end

   assign vgaRed   = pix_q.r;
   assign vgaGreen = pix_q.g;
   assign vgaBlue  = pix_q.b;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_frame_reader                                                  |
// | Self-checking bench: small-geometry DUTs for RD_LAT 1..4 against a   |
// | pixel-arithmetic model, plus a default-geometry DUT with a table.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_vga_frame_reader;
   import vga_pkg::*;

   localparam int S_IMG_W  = 6;
   localparam int S_IMG_H  = 4;
   localparam int S_SCR_W  = 14;
   localparam int S_SCR_H  = 10;
   localparam int S_ADDR_W = 5;
   localparam int S_HTOT   = 16;
   localparam int S_VTOT   = 11;
   localparam int NLAT     = 4;
   localparam int D_SCR_W  = 640;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   int   shown    = 0;
   int   cyc      = 0;

   // ---------------- small-geometry DUTs, one per read latency ----------
   logic [9:0]  sx = '0;
   logic [8:0]  sy = '0;
   logic        sde = 1'b0;
   logic [1:0]  smode = '0;
   logic [11:0] sborder = 12'h000;
   logic                s_en   [NLAT];
   logic [S_ADDR_W-1:0] s_addr [NLAT];
   logic                s_de   [NLAT];
   logic [11:0]         s_rgb  [NLAT];

   for (genvar k = 0; k < NLAT; k++) begin : g_lat
      vga_frame_reader_if #(.ADDR_W(S_ADDR_W)) bus ();
      logic [11:0] rd_q [k+1];
      logic [3:0]  r, g, b;
      always @(posedge clk) begin
         rd_q[0] <= 12'(bus.rAddr);
         for (int i = 1; i <= k; i++) rd_q[i] <= rd_q[i-1];
      end
      assign bus.rData = rd_q[k];
      vga_frame_reader #(
         .IMG_W(S_IMG_W), .IMG_H(S_IMG_H), .SCR_W(S_SCR_W), .SCR_H(S_SCR_H),
         .ADDR_W(S_ADDR_W), .RD_LAT(k + 1)
      ) dut (
         .clk(clk), .reset_n(reset_n), .x_coor(sx), .y_coor(sy),
         .display_en(sde), .mode(smode), .border_rgb(sborder), .bram(bus),
         .de(s_de[k]), .vgaRed(r), .vgaGreen(g), .vgaBlue(b)
      );
      assign s_en[k]   = bus.rEn;
      assign s_addr[k] = bus.rAddr;
      assign s_rgb[k]  = {r, g, b};
   end

   // ---------------- default-geometry DUT, RD_LAT = 1 -------------------
   logic [9:0]  dx = '0;
   logic [8:0]  dy = '0;
   logic        dde = 1'b0;
   logic [1:0]  dmode = '0;
   logic [11:0] dborder = 12'hA5C;
   logic [11:0] d_rd_q;
   logic        d_de;
   logic [3:0]  d_r, d_g, d_b;
   vga_frame_reader_if #(.ADDR_W(17)) dbus ();
   always @(posedge clk) d_rd_q <= dbus.rAddr[11:0];
   assign dbus.rData = d_rd_q;
   vga_frame_reader #(.RD_LAT(1)) d_dut (
      .clk(clk), .reset_n(reset_n), .x_coor(dx), .y_coor(dy),
      .display_en(dde), .mode(dmode), .border_rgb(dborder), .bram(dbus),
      .de(d_de), .vgaRed(d_r), .vgaGreen(d_g), .vgaBlue(d_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (shown < 40) begin
            shown++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
         end
      end
   endtask

   // ---------------- reference model (pixel arithmetic) ------------------
   typedef struct { bit en; int addr; bit de; int rgb; } exp_t;
   exp_t hist [64];
   int   m_mode = 0;
   bit   m_ok   = 1'b0;
   int   ucnt [S_IMG_W*S_IMG_H];
   bit   counting = 1'b0;
   int   max_addr = 0;

   function automatic int norm_mode(input int md);
      return (md == 1 || md == 2) ? md : 0;
   endfunction

   function automatic void ref_pixel(input int x, input int y, input int md,
                                     output bit win, output int addr);
      int xi, yi, w, h;
      xi = x; yi = y; w = S_IMG_W; h = S_IMG_H;
      if (md == 1) begin w = 2 * S_IMG_W; h = 2 * S_IMG_H; end
      if (md == 2) begin
         xi = x - (S_SCR_W - S_IMG_W) / 2;
         yi = y - (S_SCR_H - S_IMG_H) / 2;
      end
      win = (xi >= 0) && (yi >= 0) && (xi < w) && (yi < h);
      if (md == 1) begin xi = xi / 2; yi = yi / 2; end
      addr = win ? yi * S_IMG_W + xi : 0;
   endfunction

   task automatic check_small();
      if (cyc > 8) begin
         for (int k = 0; k < NLAT; k++) begin
            exp_t a, c;
            a = hist[(cyc - 1) % 64];
            c = hist[(cyc - (k + 3)) % 64];
            chk($sformatf("rd lat%0d", k + 1), {s_en[k], s_addr[k]}, {a.en, 5'(a.addr)});
            chk($sformatf("pix lat%0d", k + 1), {s_de[k], s_rgb[k]}, {c.de, 12'(c.rgb)});
         end
      end
   endtask

   task automatic drive_small(input int x, input int y, input int md, input bit rst_in);
      exp_t e;
      bit   win, de_in;
      int   addr;
      @(negedge clk);
      cyc++;
      check_small();
      if (counting && s_en[0]) begin
         if (int'(s_addr[0]) < S_IMG_W * S_IMG_H) ucnt[s_addr[0]]++;
         if (int'(s_addr[0]) > max_addr) max_addr = int'(s_addr[0]);
      end
      de_in = (x < S_SCR_W) && (y < S_SCR_H);
      if (!rst_in && reset_n) begin
         for (int i = 1; i <= 6; i++) hist[(cyc - i) % 64] = '{0, 0, 0, 0};
         reset_n = 1'b0;
         #1;
         for (int k = 0; k < NLAT; k++)
            chk("reset immediate", {s_en[k], s_addr[k], s_de[k], s_rgb[k]}, 32'd0);
      end
      reset_n = rst_in;
      sx = 10'(x); sy = 9'(y); sde = de_in; smode = 2'(md);
      if (!rst_in) begin
         m_ok = 1'b0; m_mode = 0;
         e = '{0, 0, 0, 0};
      end else begin
         if (x == 0 && y == 0) begin m_mode = norm_mode(md); m_ok = 1'b1; end
         ref_pixel(x, y, m_mode, win, addr);
         e.en   = de_in && win && m_ok;
         e.addr = e.en ? addr : 0;
         e.de   = de_in;
         e.rgb  = !de_in ? 0 : (e.en ? (addr & 'hFFF) : int'(sborder));
      end
      hist[cyc % 64] = e;
   endtask

   // One full small raster; mode may change from sw_row on, reset pulses 3 pixels
   task automatic run_frame(input int md, input int sw_row, input int sw_md,
                            input int rst_row, input int rst_col);
      for (int y = 0; y < S_VTOT; y++) begin
         for (int x = 0; x < S_HTOT; x++) begin
            if (x == 0 && y == 0) sborder = 12'($urandom);
            drive_small(x, y, (y >= sw_row) ? sw_md : md,
                        !(y == rst_row && x >= rst_col && x < rst_col + 3));
         end
      end
   endtask

   task automatic drive_d(input int x, input int y, input bit de_in, input int md);
      @(negedge clk);
      dx = 10'(x); dy = 9'(y); dde = de_in; dmode = 2'(md);
   endtask

   // ---------------- default-geometry vector table -----------------------
   typedef struct { int md; int y0; int tx; int ty; bit en; int addr; } vec_t;
   localparam int NV = 15;
   vec_t tbl [NV];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{0,   0,   5,   2, 1, 645};
      tbl[1]  = '{3,   0,   5,   2, 1, 645};
      tbl[2]  = '{0,  10, 400,  10, 0, 0};
      tbl[3]  = '{0,   0, 320,   0, 0, 0};
      tbl[4]  = '{1,   0,   0,   0, 1, 0};
      tbl[5]  = '{1,   0,   1,   0, 1, 0};
      tbl[6]  = '{1,   0,   0,   1, 1, 0};
      tbl[7]  = '{1,   0,   1,   1, 1, 0};
      tbl[8]  = '{1,   0, 639,   1, 1, 319};
      tbl[9]  = '{1,   0,   2,   3, 1, 321};
      tbl[10] = '{2, 120, 160, 120, 1, 0};
      tbl[11] = '{2, 120, 159, 120, 0, 0};
      tbl[12] = '{2, 120, 165, 121, 1, 325};
      tbl[13] = '{2, 120, 479, 120, 1, 319};
      tbl[14] = '{2,   0,   0,   0, 0, 0};
      for (int i = 0; i < 64; i++) hist[i] = '{0, 0, 0, 0};

      // Power-on reset, then release during blanking
      repeat (4) drive_small(S_HTOT - 1, S_VTOT - 1, 0, 1'b0);
      repeat (4) drive_small(S_HTOT - 1, S_VTOT - 1, 0, 1'b1);

      // Directed frames
      run_frame(0, 99, 0, -1, 0);
      for (int a = 0; a < S_IMG_W * S_IMG_H; a++) ucnt[a] = 0;
      max_addr = 0;
      counting = 1'b1;
      run_frame(1, 99, 1, -1, 0);
      counting = 1'b0;
      for (int a = 0; a < S_IMG_W * S_IMG_H; a++)
         chk($sformatf("upscale hits addr %0d", a), ucnt[a], 4);
      chk("upscale last addr", max_addr, S_IMG_W * S_IMG_H - 1);
      run_frame(0, 3, 1, -1, 0);          // mode change mid-frame: ignored
      run_frame(1, 99, 1, -1, 0);         // takes effect from next frame start
      run_frame(2, 5, 0, -1, 0);
      run_frame(3, 99, 3, -1, 0);
      run_frame(0, 99, 0, 4, 5);          // reset mid-line
      run_frame(2, 99, 2, 5, 2);
      run_frame(1, 99, 1, -1, 0);

      // Randomised frames
      for (int f = 0; f < 30; f++) begin
         int md, swr, swm, rr, rc;
         md  = $urandom_range(0, 3);
         swr = $urandom_range(0, 12);
         swm = $urandom_range(0, 3);
         rr  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : -1;
         rc  = $urandom_range(0, 12);
         run_frame(md, swr, swm, rr, rc);
      end
      repeat (8) drive_small(S_HTOT - 1, S_VTOT - 1, 0, 1'b1);

      // Default-geometry spot checks
      for (int v = 0; v < NV; v++) begin
         drive_d(0, 0, 1'b1, tbl[v].md);
         for (int y = tbl[v].y0; y <= tbl[v].ty; y++) begin
            for (int x = (y == 0) ? 1 : 0; x <= ((y == tbl[v].ty) ? tbl[v].tx : D_SCR_W - 1); x++)
               drive_d(x, y, 1'b1, tbl[v].md);
         end
         @(negedge clk);
         chk($sformatf("vec%0d rEn/rAddr", v), {dbus.rEn, dbus.rAddr}, {tbl[v].en, 17'(tbl[v].addr)});
         dx = 10'd700; dde = 1'b0;
         @(negedge clk);
         @(negedge clk);
         chk($sformatf("vec%0d de/rgb", v), {d_de, d_r, d_g, d_b},
             {1'b1, tbl[v].en ? 12'(tbl[v].addr) : dborder});
         @(negedge clk);
         chk($sformatf("vec%0d blank", v), {d_de, d_r, d_g, d_b}, 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_frame_reader.md
# vga_frame_reader

Parametrised framebuffer read controller between the VGA timing generator and the frame-buffer BRAM read port. It converts raster coordinates into BRAM read addresses using counters only, with no multiplier. It supports native, 2x-upscaled and centred placement of the stored image. It compensates the BRAM read latency so that colour and `de` leave the block aligned with each other.

## Interface
Parameters:
- `IMG_W`, 320: stored image width in pixels.
- `IMG_H`, 240: stored image height in pixels.
- `SCR_W`, 640: visible screen width.
- `SCR_H`, 480: visible screen height.
- `ADDR_W`, 17: BRAM address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H.
- `RD_LAT`, 1: BRAM read latency in cycles, 1..4.

Ports (clock and reset first):
- `clk`  in  1  pixel clock; also drives the BRAM read port.
- `reset_n`  in  1  asynchronous, active-low reset.
- `x_coor`  in  10  raster x from the timing generator.
- `y_coor`  in  9  raster y from the timing generator.
- `display_en`  in  1  visible-area flag from the timing generator.
- `mode`  in  2  placement mode: 0 NATIVE, 1 UPSCALE2X, 2 CENTER, 3 reserved (treated as NATIVE).
- `border_rgb`  in  12  colour driven for visible pixels outside the image window.
- `rEn`  out  1  BRAM read enable.
- `rAddr`  out  ADDR_W  BRAM read address.
- `rData`  in  12  BRAM read data, RGB444.
- `de`  out  1  delayed `display_en`.
- `vgaRed`, `vgaGreen`, `vgaBlue`  out  4 each  pixel colour.

## Operation
- Window per mode:
  - NATIVE: [0,IMG_W)×[0,IMG_H).
  - UPSCALE2X: [0,2·IMG_W)×[0,2·IMG_H).
  - CENTER: offset by X_OFF=(SCR_W−IMG_W)/2 and Y_OFF=(SCR_H−IMG_H)/2.
- Address rule (must hold exactly): rAddr = (yi)·IMG_W + xi.
  - xi, yi are the in-window coordinates.
  - In UPSCALE2X, xi and yi are halved (truncating).
- Address generation uses counters:
  - `row_base` register: cleared at frame start. Advances by IMG_W at the end of each window line; in UPSCALE2X, only after odd lines.
  - Column counter: cleared at window-line start. Increments every window pixel; in UPSCALE2X, every second pixel.
- Frame start is x_coor==0 && y_coor==0. At frame start:
  - `mode` is latched into `mode_q`.
  - `frame_ok` is set.
- A change of `mode` mid-frame has no effect until the next frame start.
- `rEn` = 1 only when display_en=1, frame_ok=1 and the pixel is inside the window. Otherwise rAddr=0.
- Colour output:
  - Pixel that issued a read: rData.
  - Visible pixel outside the window, or visible pixel while frame_ok=0: `border_rgb`.
  - display_en=0: 0.
- Reset values:
  - rEn=0, rAddr=0, de=0, RGB=0.
  - mode_q=NATIVE, frame_ok=0.
  - row_base=0, column counter=0.
  - All delay-pipe stages cleared.
- Reset mid-frame: outputs return to their reset values immediately. Image output stays suppressed (border only) until the next frame start.

## Timing
- Input sampled at cycle t. rEn and rAddr are registered and valid at t+1.
- rData arrives at t+1+RD_LAT. Colour and `de` are registered and valid at t+2+RD_LAT.
- Total latency LAT = RD_LAT+2, fixed for every pixel, including border and blanked pixels.
- The in-window flag and the `display_en` flag travel through the same LAT−1 stage delay pipe, so colour and `de` never skew.
- Throughput: one pixel per clock, no stalls, no backpressure.
- Wrap: the last window pixel of the frame addresses IMG_W·IMG_H−1. The next address used is 0, after the frame-start clear.

## Structure
- `vga_pkg` (shared package) holds:
  - `vga_mode_e` enum: NATIVE, UPSCALE2X, CENTER, RSVD.
  - `rgb444_t` packed struct.
  - Default screen and image dimension constants.
- Sub-module `vga_pipe_delay`: parametrised depth and width, async active-low reset to 0. Instantiated once for {in-window, display_en}.
- Address counters, window compare and output register are in the top module.

## Test plan
- NATIVE, RD_LAT=1, BRAM model returning data = address[11:0]:
  - Pixel (5,2) → RGB=12'h285 and de=1 exactly 3 cycles after the input.
  - Pixel (400,10) → `border_rgb`, rEn=0.
- UPSCALE2X:
  - Pixels (0,0), (1,0), (0,1), (1,1) → rAddr=0.
  - Pixel (639,479) → rAddr=76799.
  - Each address is issued on exactly 4 pixels per frame.
- CENTER:
  - Pixel (160,120) → rAddr=0.
  - Pixel (159,120) → `border_rgb`.
  - Pixel (479,359) → rAddr=76799.
- `mode` switched NATIVE→UPSCALE2X at y=100 → addresses unchanged until the next (0,0), then UPSCALE2X addressing.
- Sweep RD_LAT=1..4 → latency = RD_LAT+2 on every pixel; de and RGB aligned; blanking outputs RGB=0.
- Assert reset_n low mid-line for 3 cycles → all outputs 0 immediately; border-only output until next frame start; correct addressing in the following frame.
